// File: rtl/fpnew_req_scheduler.sv
// Round-robin request scheduler sharing one FPU opgroup datapath among NumReq requesters.
// Tracks per-requester in-flight operations and routes tagged responses back to their owner.
module fpnew_req_scheduler #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned RspWidth       = 38,
    localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clr_i,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][DataWidth-1:0]  req_data_i,
    output logic                              fpu_valid_o,
    input  logic                              fpu_ready_i,
    output logic [DataWidth-1:0]              fpu_data_o,
    output logic [IdWidth-1:0]                fpu_id_o,
    input  logic                              fpu_rsp_valid_i,
    output logic                              fpu_rsp_ready_o,
    input  logic [IdWidth-1:0]                fpu_rsp_id_i,
    input  logic [RspWidth-1:0]               fpu_rsp_data_i,
    output logic [NumReq-1:0]                 rsp_valid_o,
    input  logic [NumReq-1:0]                 rsp_ready_i,
    output logic [RspWidth-1:0]               rsp_data_o,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = IdWidth + 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   hold_idx_q, hold_idx_d;
    logic [IdWidth-1:0]   rr_ptr_q;
    logic [CntWidth-1:0]  cnt_q [NumReq];
    logic [CntWidth-1:0]  cnt_d [NumReq];
    logic                 err_q;

    logic [NumReq-1:0]    eligible;
    logic                 rr_found;
    logic [IdWidth-1:0]   rr_idx;
    logic [PtrWidth-1:0]  cand;
    logic                 grant_valid;
    logic [IdWidth-1:0]   grant_idx;
    logic                 issue;
    logic                 rsp_id_ok;
    logic                 rsp_hs;
    logic                 rsp_err;
    logic [NumReq-1:0]    inc_vec;
    logic [NumReq-1:0]    dec_vec;
    logic                 any_cnt;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    // Search starts at rr_ptr and wraps; cand carries one spare bit so the sum cannot overflow.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_q} + PtrWidth'(k);
            if (cand >= PtrWidth'(NumReq)) begin
                cand = cand - PtrWidth'(NumReq);
            end
            if (!rr_found && eligible[cand[IdWidth-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IdWidth-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_idx_d  = hold_idx_q;
        grant_valid = rr_found;
        grant_idx   = rr_idx;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (rr_found && !fpu_ready_i) begin
                    state_d    = HOLD;
                    hold_idx_d = rr_idx;
                end
            end
            HOLD: begin
                grant_valid = 1'b1;
                grant_idx   = hold_idx_q;
                if (fpu_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_valid && fpu_ready_i) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign fpu_valid_o = grant_valid;
    assign fpu_id_o    = grant_idx;
    assign fpu_data_o  = req_data_i[grant_idx];
    assign issue       = grant_valid && fpu_ready_i;

    // Out-of-range tags are accepted so the bogus response drains and raises err_o instead of stalling.
    assign rsp_id_ok       = ({1'b0, fpu_rsp_id_i} < PtrWidth'(NumReq));
    assign fpu_rsp_ready_o = rsp_id_ok ? rsp_ready_i[fpu_rsp_id_i] : 1'b1;
    assign rsp_data_o      = fpu_rsp_data_i;
    assign rsp_hs          = fpu_rsp_valid_i && fpu_rsp_ready_o;
    assign rsp_err         = rsp_hs && (!rsp_id_ok || (cnt_q[fpu_rsp_id_i] == '0));

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            rsp_valid_o[k] = fpu_rsp_valid_i && rsp_id_ok && (fpu_rsp_id_i == IdWidth'(k));
        end
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            inc_vec[i] = issue && (grant_idx == IdWidth'(i)) && (cnt_q[i] < CntWidth'(MaxOutstanding));
            dec_vec[i] = rsp_hs && !rsp_err && (fpu_rsp_id_i == IdWidth'(i));
            cnt_d[i]   = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
            if (cnt_q[i] != '0) begin
                any_cnt = 1'b1;
            end
        end
    end

    assign busy_o = fpu_valid_o || any_cnt;
    assign err_o  = err_q;

    // clr_i wins over any same-cycle handshake, exactly like reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clr_i) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
            if (issue) begin
                rr_ptr_q <= (grant_idx == IdWidth'(NumReq - 1)) ? '0 : grant_idx + IdWidth'(1);
            end
            if (rsp_err) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < NumReq; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/fpnew_req_scheduler.md
FPNEW_REQ_SCHEDULER -- requirements
Module: fpnew_req_scheduler

Interface
REQ-001 Parameter NumReq, default 2, number of requesters sharing one FPU opgroup datapath; legal range 2..8.
REQ-002 Parameter MaxOutstanding, default 4, maximum in-flight operations per requester; legal range 1..15.
REQ-003 Parameter DataWidth, default 64, width of the opaque request payload.
REQ-004 Parameter RspWidth, default 38, width of the opaque response payload.
REQ-005 Parameter IdWidth, localparam, equal to max(1, clog2(NumReq)).
REQ-006 clk_i  in  1  single clock; all state is rising-edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 clr_i  in  1  synchronous clear, same effect as reset.
REQ-009 req_valid_i  in  NumReq  per-requester request valid.
REQ-010 req_ready_o  out  NumReq  per-requester request accept.
REQ-011 req_data_i  in  NumReq x DataWidth  per-requester payload.
REQ-012 fpu_valid_o / fpu_ready_i  out / in  1 / 1  issue handshake toward the datapath.
REQ-013 fpu_data_o / fpu_id_o  out  DataWidth / IdWidth  issued payload and requester index (carried in the datapath tag).
REQ-014 fpu_rsp_valid_i / fpu_rsp_ready_o  in / out  1 / 1  result handshake from the datapath.
REQ-015 fpu_rsp_id_i / fpu_rsp_data_i  in  IdWidth / RspWidth  returned tag index and result.
REQ-016 rsp_valid_o / rsp_ready_i  out / in  NumReq / NumReq  per-requester response handshake.
REQ-017 rsp_data_o  out  RspWidth  response payload, shared by all requesters.
REQ-018 busy_o  out  1  high while any operation is pending or in flight.
REQ-019 err_o  out  1  sticky protocol-error flag.

Function
REQ-020 Eligibility SHALL be req_valid_i[i] AND cnt[i] < MaxOutstanding.
REQ-021 Arbitration SHALL be round-robin: the first eligible index at or above rr_ptr wins, searching with wrap-around.
REQ-022 FSM states: IDLE (no grant held) and HOLD (grant held).
- IDLE -> HOLD when a grant exists and fpu_ready_i=0.
- HOLD -> IDLE on fpu_ready_i=1.
REQ-023 In HOLD, the grant index, fpu_data_o and fpu_id_o SHALL remain frozen, and fpu_valid_o SHALL stay 1 (valid/data stability).
REQ-024 fpu_valid_o SHALL be 1 iff a grant exists.
- fpu_data_o = req_data_i[grant], combinational, zero-latency path.
REQ-025 req_ready_o[i] SHALL be fpu_ready_i AND (grant==i); all other bits are 0.
REQ-026 On an issue handshake, rr_ptr SHALL become (grant+1) mod NumReq and cnt[grant] SHALL increment.
REQ-027 Response routing:
- rsp_valid_o[k] = fpu_rsp_valid_i AND (fpu_rsp_id_i==k).
- fpu_rsp_ready_o = rsp_ready_i[fpu_rsp_id_i].
- rsp_data_o = fpu_rsp_data_i.
REQ-028 On a response handshake, cnt[fpu_rsp_id_i] SHALL decrement.
REQ-029 Issue and response to the same requester in one cycle SHALL leave its cnt unchanged.
REQ-030 A response handshake when cnt[id]==0, or with fpu_rsp_id_i >= NumReq, SHALL set err_o and leave cnt unchanged.
REQ-031 cnt SHALL never exceed MaxOutstanding and never wrap.
REQ-032 busy_o SHALL be fpu_valid_o OR (any cnt != 0).
REQ-033 clr_i SHALL take priority over a same-cycle handshake.
- Clears cnt, rr_ptr, FSM and err_o.
- Outputs follow in the next cycle.

Reset
REQ-034 Under rst_ni=0, asynchronously:
- cnt=0, rr_ptr=0, FSM=IDLE, err_o=0.
- Hence fpu_valid_o=0 while req_valid_i=0, req_ready_o=0, busy_o=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight accounting; responses arriving after reset for pre-reset issues SHALL flag err_o.

Verification
REQ-036 Scenario: NumReq=2, both requesters valid, fpu_ready_i=1 for 4 cycles -> grants 0,1,0,1; cnt={2,2}.
REQ-037 Scenario: req 1 valid with data 0xA5, fpu_ready_i=0 for 3 cycles then 1, and req 0 raised at cycle 1 -> grant held on 1, fpu_data_o=0xA5 constant, issue on cycle 3, then grant 0.
REQ-038 Scenario: MaxOutstanding=4, req 0 issues 4 times with no responses -> req 0 blocked, req 1 still granted; one response id=0 -> req 0 eligible next cycle.
REQ-039 Scenario: cnt[0]=2, same-cycle issue by 0 and response id=0 -> cnt[0]=2; rsp_valid_o=01, rsp_data_o=fpu_rsp_data_i.
REQ-040 Scenario: response id=1 with cnt[1]=0 -> err_o=1 and sticky; clr_i pulse -> err_o=0, busy_o=0.
REQ-041 Scenario: rst_ni low for 1 cycle mid-HOLD with cnt={3,1} -> all counters 0, fpu_valid_o follows req_valid_i from rr_ptr=0.
